// File: rtl/rotate_pkg.sv
// Shared types and defaults for the image-rotate sequencing controller.
package rotate_pkg;

  localparam int DIM_W_DEF  = 12;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ROT_COPY = 2'b00,
    ROT_90   = 2'b01,
    ROT_180  = 2'b10,
    ROT_270  = 2'b11
  } rot_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } rot_state_e;

endpackage

// File: rtl/rotate_addr_gen.sv
// Raster x/y walker with running source and rotated destination offsets.
// init_i loads the per-mode anchor; step_i advances one pixel.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic              step_i,
  input  logic [1:0]        mode_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  output logic [ADDR_W-1:0] src_off_o,
  output logic [ADDR_W-1:0] dst_off_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);

  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d, row_q, row_d;
  logic [2*DIM_W-1:0] area_s;
  logic [ADDR_W-1:0]  h_s, area_ext_s;
  logic               x_end_s, y_end_s;

  // The image area is needed once, as the starting anchor for 180/270;
  // every per-pixel step afterwards is a plain add/subtract.
  assign area_s     = {{DIM_W{1'b0}}, width_i} * {{DIM_W{1'b0}}, height_i};
  assign area_ext_s = ADDR_W'(area_s);
  assign h_s        = ADDR_W'(height_i);
  assign x_end_s    = (x_q == width_i - DIM_ONE);
  assign y_end_s    = (y_q == height_i - DIM_ONE);

  assign src_off_o = src_q;
  assign dst_off_o = dst_q;
  assign last_o    = x_end_s & y_end_s;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    src_d = src_q;
    dst_d = dst_q;
    row_d = row_q;
    if (init_i) begin
      x_d   = '0;
      y_d   = '0;
      src_d = '0;
      case (rot_mode_e'(mode_i))
        ROT_90:  begin row_d = h_s - ADDR_ONE;        dst_d = h_s - ADDR_ONE;        end
        ROT_180: begin row_d = '0;                    dst_d = area_ext_s - ADDR_ONE; end
        ROT_270: begin row_d = area_ext_s - h_s;      dst_d = area_ext_s - h_s;      end
        default: begin row_d = '0;                    dst_d = '0;                    end
      endcase
    end else if (step_i) begin
      src_d = src_q + ADDR_ONE;
      if (x_end_s) begin
        x_d = '0;
        y_d = y_q + DIM_ONE;
      end else begin
        x_d = x_q + DIM_ONE;
      end
      // row_q tracks the column-0 offset of the current source row for 90/270
      case (rot_mode_e'(mode_i))
        ROT_90: begin
          if (x_end_s) begin
            row_d = row_q - ADDR_ONE;
            dst_d = row_q - ADDR_ONE;
          end else begin
            dst_d = dst_q + h_s;
          end
        end
        ROT_180: dst_d = dst_q - ADDR_ONE;
        ROT_270: begin
          if (x_end_s) begin
            row_d = row_q + ADDR_ONE;
            dst_d = row_q + ADDR_ONE;
          end else begin
            dst_d = dst_q - h_s;
          end
        end
        default: dst_d = dst_q + ADDR_ONE;
      endcase
    end else begin
      src_d = src_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      src_q <= '0;
      dst_q <= '0;
      row_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      src_q <= src_d;
      dst_q <= dst_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/rotate_ctrl.sv
// Image-rotate sequencer: one read then one write per source pixel,
// with zero-size rejection, deferred abort and a sticky interrupt.
module rotate_ctrl
  import rotate_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              I_PCLK,
  input  logic              I_PRESET_N,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic [1:0]        I_MODE,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic [ADDR_W-1:0] I_SRC_BASE,
  input  logic [ADDR_W-1:0] I_DST_BASE,
  input  logic              I_IRQ_CLR,
  output logic              O_RD_REQ,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic              I_RD_ACK,
  input  logic [DATA_W-1:0] I_RD_DATA,
  output logic              O_WR_REQ,
  output logic [ADDR_W-1:0] O_WR_ADDR,
  output logic [DATA_W-1:0] O_WR_DATA,
  input  logic              I_WR_ACK,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR,
  output logic              O_ABORTED,
  output logic              O_IRQ
);

  rot_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              abort_q, abort_d, err_q, err_d, aborted_q, aborted_d, irq_q, irq_d;
  logic              busy_s, abort_seen_s, init_s, step_s, last_s;
  logic [ADDR_W-1:0] src_off_s, dst_off_s;

  assign busy_s       = (state_q == ST_CHECK) || (state_q == ST_RD) || (state_q == ST_WR);
  assign abort_seen_s = abort_q | I_ABORT;
  assign init_s       = (state_q == ST_CHECK);

  rotate_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i     (I_PCLK),
    .rst_ni    (I_PRESET_N),
    .init_i    (init_s),
    .step_i    (step_s),
    .mode_i    (mode_q),
    .width_i   (w_q),
    .height_i  (h_q),
    .src_off_o (src_off_s),
    .dst_off_o (dst_off_s),
    .last_o    (last_s)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    w_d       = w_q;
    h_d       = h_q;
    src_d     = src_q;
    dst_d     = dst_q;
    pix_d     = pix_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    step_s    = 1'b0;
    abort_d   = (busy_s && I_ABORT) ? 1'b1 : abort_q;
    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          state_d   = ST_CHECK;
          mode_d    = I_MODE;
          w_d       = I_WIDTH;
          h_d       = I_HEIGHT;
          src_d     = I_SRC_BASE;
          dst_d     = I_DST_BASE;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          abort_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (abort_seen_s) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if ((w_q == '0) || (h_q == '0)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (I_RD_ACK) begin
          pix_d   = I_RD_DATA;
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        // abort only takes effect here, after the write handshake completes
        if (I_WR_ACK) begin
          if (last_s || abort_seen_s) begin
            state_d   = ST_DONE;
            aborted_d = abort_seen_s;
          end else begin
            step_s  = 1'b1;
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q == ST_DONE) begin
      irq_d = 1'b1;
    end else if (I_IRQ_CLR) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      w_q       <= '0;
      h_q       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      pix_q     <= '0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      w_q       <= w_d;
      h_q       <= h_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      pix_q     <= pix_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
      irq_q     <= irq_d;
    end
  end

  assign O_RD_REQ  = (state_q == ST_RD);
  assign O_RD_ADDR = O_RD_REQ ? (src_q + src_off_s) : '0;
  assign O_WR_REQ  = (state_q == ST_WR);
  assign O_WR_ADDR = O_WR_REQ ? (dst_q + dst_off_s) : '0;
  assign O_WR_DATA = O_WR_REQ ? pix_q : '0;
  assign O_BUSY    = busy_s;
  assign O_DONE    = (state_q == ST_DONE);
  assign O_ERR     = err_q;
  assign O_ABORTED = aborted_q;
  assign O_IRQ     = irq_q;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Scoreboard bench for rotate_ctrl: memory responders with random ack delay,
// formula-based reference model, queue-driven checker.
module tb_rotate_ctrl;

  logic        clk = 1'b0;
  logic        I_PRESET_N = 1'b0;
  logic        I_START = 1'b0;
  logic        I_ABORT = 1'b0;
  logic [1:0]  I_MODE = 2'd0;
  logic [11:0] I_WIDTH = 12'd0;
  logic [11:0] I_HEIGHT = 12'd0;
  logic [31:0] I_SRC_BASE = 32'd0;
  logic [31:0] I_DST_BASE = 32'd0;
  logic        I_IRQ_CLR = 1'b0;
  logic        I_RD_ACK = 1'b0;
  logic [7:0]  I_RD_DATA = 8'd0;
  logic        I_WR_ACK = 1'b0;
  logic        O_RD_REQ, O_WR_REQ, O_BUSY, O_DONE, O_ERR, O_ABORTED, O_IRQ;
  logic [31:0] O_RD_ADDR, O_WR_ADDR;
  logic [7:0]  O_WR_DATA;

  rotate_ctrl dut (
    .I_PCLK(clk), .I_PRESET_N(I_PRESET_N), .I_START(I_START), .I_ABORT(I_ABORT),
    .I_MODE(I_MODE), .I_WIDTH(I_WIDTH), .I_HEIGHT(I_HEIGHT),
    .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE), .I_IRQ_CLR(I_IRQ_CLR),
    .O_RD_REQ(O_RD_REQ), .O_RD_ADDR(O_RD_ADDR), .I_RD_ACK(I_RD_ACK), .I_RD_DATA(I_RD_DATA),
    .O_WR_REQ(O_WR_REQ), .O_WR_ADDR(O_WR_ADDR), .O_WR_DATA(O_WR_DATA), .I_WR_ACK(I_WR_ACK),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR), .O_ABORTED(O_ABORTED), .O_IRQ(O_IRQ)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] data; } exp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; bit acked; } obs_t;

  exp_t exp_rd[$], exp_wr[$];
  obs_t obs_rd[$], obs_wr[$];
  logic [7:0] lut [256];
  int checks = 0, errors = 0, cyc = 0, max_dly = 0, rd_acks = 0, wr_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // destination offset straight from the rotation formulas
  function automatic logic [31:0] f_off(input int mode, input int x, input int y, input int w, input int h);
    case (mode)
      1:       return 32'(x * h + (h - 1 - y));
      2:       return 32'((h - 1 - y) * w + (w - 1 - x));
      3:       return 32'((w - 1 - x) * h + y);
      default: return 32'(y * w + x);
    endcase
  endfunction

  task automatic push_model(input int mode, input int w, input int h, input logic [31:0] src,
                            input logic [31:0] dst, input int npx);
    logic [31:0] ra;
    for (int p = 0; p < npx; p++) begin
      ra = src + 32'(p);
      exp_rd.push_back('{ra, 8'h00});
      exp_wr.push_back('{dst + f_off(mode, p % w, p / w, w, h), lut[ra[7:0]]});
    end
  endtask

  // read responder: random ack delay, records every request cycle
  initial begin
    int cnt;
    bit pend;
    cnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (I_RD_ACK) begin
        I_RD_ACK = 1'b0;
        rd_acks++;
      end
      I_RD_DATA = 8'($urandom);
      if (!I_PRESET_N) begin
        pend = 1'b0;
      end else if (O_RD_REQ) begin
        if (!pend) begin
          pend = 1'b1;
          cnt = int'($urandom_range(32'(max_dly), 32'd0));
        end
        obs_rd.push_back('{O_RD_ADDR, 8'h00, cnt == 0});
        if (cnt == 0) begin
          I_RD_ACK = 1'b1;
          I_RD_DATA = lut[O_RD_ADDR[7:0]];
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // write responder
  initial begin
    int cnt;
    bit pend;
    cnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (I_WR_ACK) begin
        I_WR_ACK = 1'b0;
        wr_acks++;
      end
      if (!I_PRESET_N) begin
        pend = 1'b0;
      end else if (O_WR_REQ) begin
        if (!pend) begin
          pend = 1'b1;
          cnt = int'($urandom_range(32'(max_dly), 32'd0));
        end
        obs_wr.push_back('{O_WR_ADDR, O_WR_DATA, cnt == 0});
        if (cnt == 0) begin
          I_WR_ACK = 1'b1;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // checker: every observed request cycle must match the head of the model queue
  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      while (obs_rd.size() > 0) begin
        o = obs_rd.pop_front();
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_extra actual=0x%0h required=none", o.addr);
        end else begin
          chk("rd_addr", 64'(o.addr), 64'(exp_rd[0].addr));
          if (o.acked) void'(exp_rd.pop_front());
        end
      end
      while (obs_wr.size() > 0) begin
        o = obs_wr.pop_front();
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra actual=0x%0h required=none", o.addr);
        end else begin
          chk("wr_addr", 64'(o.addr), 64'(exp_wr[0].addr));
          chk("wr_data", 64'(o.data), 64'(exp_wr[0].data));
          if (o.acked) void'(exp_wr.pop_front());
        end
      end
    end
  end

  task automatic run_job(input int mode, input int w, input int h, input logic [31:0] src,
                         input logic [31:0] dst, input int dly, input int abort_px, input bit busy_start);
    int npx, s_cyc, rd_base;
    bit done_seen, ab_sent, exp_err, exp_ab;
    max_dly = dly;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    I_IRQ_CLR = 1'b1;
    @(negedge clk);
    I_IRQ_CLR = 1'b0;
    chk("irq_clear", 64'(O_IRQ), 64'd0);
    exp_err = (w == 0) || (h == 0);
    exp_ab = (abort_px > 0);
    npx = exp_err ? 0 : w * h;
    if (abort_px > 0 && abort_px < npx) npx = abort_px;
    push_model(mode, w, h, src, dst, npx);
    rd_base = rd_acks;
    I_MODE = 2'(mode);
    I_WIDTH = 12'(w);
    I_HEIGHT = 12'(h);
    I_SRC_BASE = src;
    I_DST_BASE = dst;
    I_START = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    I_START = 1'b0;
    I_MODE = 2'($urandom);
    I_WIDTH = 12'($urandom);
    I_HEIGHT = 12'($urandom);
    I_SRC_BASE = $urandom;
    I_DST_BASE = $urandom;
    chk("busy_in_check", 64'(O_BUSY), 64'd1);
    chk("flags_cleared", 64'({O_ERR, O_ABORTED}), 64'd0);
    done_seen = 1'b0;
    ab_sent = 1'b0;
    for (int k = 0; k < 4000 && !done_seen; k++) begin
      @(negedge clk);
      if (I_START) I_START = 1'b0;
      if (I_ABORT) I_ABORT = 1'b0;
      if (O_DONE) begin
        done_seen = 1'b1;
      end else begin
        if (abort_px > 0 && !ab_sent && O_RD_REQ && (rd_acks - rd_base) == abort_px - 1) begin
          I_ABORT = 1'b1;
          ab_sent = 1'b1;
        end
        if (busy_start && k == 2) begin
          I_START = 1'b1;
          I_WIDTH = 12'd0;
        end
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done mode=%0d w=%0d h=%0d", mode, w, h);
    end else begin
      if (dly == 0) chk("done_latency", 64'(cyc - s_cyc), 64'(2 + 2 * npx));
      chk("err_at_done", 64'(O_ERR), 64'(exp_err));
      chk("aborted_at_done", 64'(O_ABORTED), 64'(exp_ab));
      I_IRQ_CLR = 1'b1;
      @(negedge clk);
      I_IRQ_CLR = 1'b0;
      if (I_ABORT) I_ABORT = 1'b0;
      chk("done_one_cycle", 64'(O_DONE), 64'd0);
      chk("irq_set_wins", 64'(O_IRQ), 64'd1);
      chk("idle_not_busy", 64'(O_BUSY), 64'd0);
      chk("err_held", 64'(O_ERR), 64'(exp_err));
      chk("rd_all_seen", 64'(exp_rd.size()), 64'd0);
      chk("wr_all_seen", 64'(exp_wr.size()), 64'd0);
    end
  endtask

  task automatic reset_mid_wr();
    bit hit;
    int wr_base;
    max_dly = 2;
    exp_rd.delete();
    exp_wr.delete();
    push_model(0, 4, 4, 32'h0000_1200, 32'h0000_4000, 16);
    wr_base = wr_acks;
    I_MODE = 2'd0;
    I_WIDTH = 12'd4;
    I_HEIGHT = 12'd4;
    I_SRC_BASE = 32'h0000_1200;
    I_DST_BASE = 32'h0000_4000;
    I_START = 1'b1;
    @(negedge clk);
    I_START = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      if (O_WR_REQ && (wr_acks - wr_base) >= 1) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL reset_wr_timeout actual=no_wr required=wr");
    end
    I_PRESET_N = 1'b0;
    #1;
    chk("rst_mid_addr", {O_RD_ADDR, O_WR_ADDR}, 64'd0);
    chk("rst_mid_flags", 64'({O_RD_REQ, O_WR_REQ, O_WR_DATA, O_BUSY, O_DONE, O_ERR, O_ABORTED, O_IRQ}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    exp_rd.delete();
    exp_wr.delete();
    obs_rd.delete();
    obs_wr.delete();
    I_PRESET_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_addr", {O_RD_ADDR, O_WR_ADDR}, 64'd0);
    chk("reset_flags", 64'({O_RD_REQ, O_WR_REQ, O_WR_DATA, O_BUSY, O_DONE, O_ERR, O_ABORTED, O_IRQ}), 64'd0);
    I_PRESET_N = 1'b1;

    for (int m = 0; m < 4; m++) begin
      run_job((m + 1) % 4, 3, 2, 32'h0000_1000, 32'h0000_2000, 0, 0, 1'b0);
    end
    run_job(1, 0, 5, 32'h0000_1000, 32'h0000_2000, 0, 0, 1'b0);
    run_job(1, 4, 4, 32'h0000_1000, 32'h0000_3000, 3, 0, 1'b0);
    run_job(2, 4, 4, 32'h0000_1100, 32'h0000_3100, 0, 3, 1'b0);
    reset_mid_wr();
    run_job(int'($urandom_range(3, 0)), 2, 2, 32'h0000_1300, 32'h0000_5000, 0, 0, 1'b1);
    run_job(3, 3, 0, 32'h0000_1000, 32'h0000_2000, 0, 0, 1'b0);
    run_job(2, 5, 3, 32'h0000_10F0, 32'hFFFF_FFF8, 1, 0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom_range(3, 0)), int'($urandom_range(5, 1)), int'($urandom_range(5, 1)),
              $urandom, $urandom, int'($urandom_range(2, 0)), 0, 1'b0);
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
